// File: rtl/muldiv_ctrl_if.sv
// Execute-stage <-> HI/LO unit bundle: op request, flush, MTHI/MTLO writes,
// and the stall/busy/done status with the architectural HI/LO values.
interface muldiv_ctrl_if;
  logic        valid_in;
  logic [3:0]  funct;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        flush;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] mt_wdata;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output valid_in, funct, in1, in2, flush, hi_we, lo_we, mt_wdata,
    input  stall, busy, done, hi, lo
  );

  modport slave (
    input  valid_in, funct, in1, in2, flush, hi_we, lo_we, mt_wdata,
    output stall, busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Multi-cycle HI/LO unit: counted multiply, 32-step restoring divide,
// pipeline stall generation and ownership of the HI/LO registers.
//
// state | meaning
// IDLE  | waiting for a muldiv op; start latches operands
// MUL   | counting MUL_CYCLES cycles; product written on exit
// DIV   | one restoring-divide iteration per cycle, quotient MSB first
// FIX   | sign correction, quotient -> LO, remainder -> HI
// DONE  | one-cycle done pulse, stall released
module muldiv_ctrl #(
  parameter int MUL_CYCLES = 4
) (
  input logic          clk,
  input logic          reset,
  muldiv_ctrl_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  localparam logic [3:0] F_MULT  = 4'b1011;
  localparam logic [3:0] F_MULTU = 4'b1100;
  localparam logic [3:0] F_DIV   = 4'b1101;
  localparam logic [3:0] F_DIVU  = 4'b1110;
  localparam logic [4:0] MUL_LAST = 5'(MUL_CYCLES - 1);
  localparam logic [4:0] DIV_LAST = 5'd31;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] opa_q, opa_d;   // multiplicand, or dividend shifting into the quotient
  logic [31:0] opb_q, opb_d;
  logic [31:0] rem_q, rem_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        is_op, is_mul, start;
  logic [63:0] ext_a, ext_b, product;
  logic [32:0] rem_shift, rem_diff;
  logic [31:0] quo_fix, rem_fix;
  logic        res_we;
  logic [31:0] res_hi, res_lo;

  assign is_mul = (bus.funct == F_MULT) || (bus.funct == F_MULTU);
  assign is_op  = is_mul || (bus.funct == F_DIV) || (bus.funct == F_DIVU);
  assign start  = bus.valid_in && is_op && (state_q == S_IDLE) && !bus.flush;

  // Sign-extending to 64 bits makes the truncated unsigned product the signed one.
  assign ext_a   = (op_q == F_MULT) ? {{32{opa_q[31]}}, opa_q} : {32'b0, opa_q};
  assign ext_b   = (op_q == F_MULT) ? {{32{opb_q[31]}}, opb_q} : {32'b0, opb_q};
  assign product = ext_a * ext_b;

  assign rem_shift = {rem_q, opa_q[31]};
  assign rem_diff  = rem_shift - {1'b0, opb_q};

  assign quo_fix = (op_q == F_DIV && neg_quo_q) ? -opa_q : opa_q;
  assign rem_fix = (op_q == F_DIV && neg_rem_q) ? -rem_q : rem_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    rem_d     = rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    res_we    = 1'b0;
    res_hi    = product[63:32];
    res_lo    = product[31:0];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = bus.funct;
          cnt_d = 5'd0;
          rem_d = 32'd0;
          if (bus.funct == F_DIV) begin
            opa_d     = bus.in1[31] ? -bus.in1 : bus.in1;
            opb_d     = bus.in2[31] ? -bus.in2 : bus.in2;
            neg_quo_d = bus.in1[31] ^ bus.in2[31];
            neg_rem_d = bus.in1[31];
          end else begin
            opa_d     = bus.in1;
            opb_d     = bus.in2;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
          end
          if (is_mul)                  state_d = S_MUL;
          else if (bus.in2 == 32'd0)   state_d = S_DONE;
          else                         state_d = S_DIV;
        end
      end
      S_MUL: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == MUL_LAST) begin
          state_d = S_DONE;
          res_we  = 1'b1;
        end
      end
      S_DIV: begin
        cnt_d = cnt_q + 5'd1;
        if (!rem_diff[32]) begin
          rem_d = rem_diff[31:0];
          opa_d = {opa_q[30:0], 1'b1};
        end else begin
          rem_d = rem_shift[31:0];
          opa_d = {opa_q[30:0], 1'b0};
        end
        if (cnt_q == DIV_LAST) state_d = S_FIX;
      end
      S_FIX: begin
        res_we  = 1'b1;
        res_hi  = rem_fix;
        res_lo  = quo_fix;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (bus.flush) begin
      state_d = S_IDLE;
      cnt_d   = 5'd0;
      res_we  = 1'b0;
    end
  end

  // MTHI/MTLO take priority over a coinciding result write, per register.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (res_we) begin
      hi_d = res_hi;
      lo_d = res_lo;
    end
    if (bus.hi_we) hi_d = bus.mt_wdata;
    if (bus.lo_we) lo_d = bus.mt_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      op_q      <= 4'd0;
      opa_q     <= 32'd0;
      opb_q     <= 32'd0;
      rem_q     <= 32'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      rem_q     <= rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.busy  = (state_q != S_IDLE);
  assign bus.done  = (state_q == S_DONE);
  assign bus.stall = start || (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed corner cases plus random ops
// compared against a plain-arithmetic HI/LO model.
module tb_muldiv_ctrl;
  localparam int MULC = 4;
  localparam logic [3:0] F_MULT  = 4'b1011;
  localparam logic [3:0] F_MULTU = 4'b1100;
  localparam logic [3:0] F_DIV   = 4'b1101;
  localparam logic [3:0] F_DIVU  = 4'b1110;

  logic clk;
  logic reset;
  muldiv_ctrl_if bus ();

  muldiv_ctrl #(.MUL_CYCLES(MULC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [3:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      F_MULT:  ref_result = 64'(sa * sb);
      F_MULTU: ref_result = ua * ub;
      F_DIV: begin
        q = sa / sb;
        r = sa % sb;
        ref_result = {r[31:0], q[31:0]};
      end
      default: ref_result = {a % b, a / b};
    endcase
  endfunction

  task automatic clear_inputs();
    bus.valid_in = 1'b0;
    bus.flush    = 1'b0;
    bus.hi_we    = 1'b0;
    bus.lo_we    = 1'b0;
  endtask

  // Called at a negedge in an IDLE cycle; returns at a negedge in an IDLE cycle.
  task automatic run_op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int flush_cyc, input int mt_cyc, input logic mt_lo,
                        input logic [31:0] mt_d);
    logic [63:0] r;
    logic [31:0] exp_hi, exp_lo;
    int lat, n;
    bit div0, seen, stall_ok;
    div0 = (f == F_DIV || f == F_DIVU) && (b == 32'd0);
    lat  = (f == F_MULT || f == F_MULTU) ? 1 + MULC : (div0 ? 1 : 34);
    exp_hi = model_hi;
    exp_lo = model_lo;
    if (!div0 && flush_cyc == 0) begin
      r = ref_result(f, a, b);
      exp_hi = r[63:32];
      exp_lo = r[31:0];
    end
    if (mt_cyc != 0) begin
      if (mt_lo) exp_lo = mt_d;
      else       exp_hi = mt_d;
    end

    bus.valid_in = 1'b1;
    bus.funct    = f;
    bus.in1      = a;
    bus.in2      = b;
    #1 chk("start_stall", bus.stall, 1);

    n = 0; seen = 0; stall_ok = 1;
    while (n < 80) begin
      @(negedge clk);
      n++;
      clear_inputs();
      if (bus.done === 1'b1) begin
        seen = 1;
        break;
      end
      if (flush_cyc != 0 && n == flush_cyc + 1) break;
      if (bus.stall !== 1'b1) stall_ok = 0;
      if (n == flush_cyc) bus.flush = 1'b1;
      if (n == mt_cyc) begin
        bus.mt_wdata = mt_d;
        if (mt_lo) bus.lo_we = 1'b1;
        else       bus.hi_we = 1'b1;
      end
    end
    chk("stall_while_busy", stall_ok, 1);
    if (flush_cyc != 0) begin
      chk("flush_no_done", seen, 0);
      chk("flush_idle", bus.busy, 0);
      chk("flush_hi", bus.hi, exp_hi);
      chk("flush_lo", bus.lo, exp_lo);
    end else begin
      chk("done_seen", seen, 1);
      chk("latency", n, lat);
      chk("done_stall", bus.stall, 0);
      chk("result_hi", bus.hi, exp_hi);
      chk("result_lo", bus.lo, exp_lo);
      @(negedge clk);
      chk("idle_after_done", bus.busy, 0);
    end
    model_hi = exp_hi;
    model_lo = exp_lo;
  endtask

  task automatic mt_write(input logic to_lo, input logic [31:0] d);
    bus.mt_wdata = d;
    if (to_lo) bus.lo_we = 1'b1;
    else       bus.hi_we = 1'b1;
    @(negedge clk);
    clear_inputs();
    if (to_lo) model_lo = d;
    else       model_hi = d;
    chk("mt_hi", bus.hi, model_hi);
    chk("mt_lo", bus.lo, model_lo);
  endtask

  logic [3:0] ops [4];
  logic [3:0] f;
  logic [31:0] a, b;

  initial begin
    ops[0] = F_MULT; ops[1] = F_MULTU; ops[2] = F_DIV; ops[3] = F_DIVU;
    reset = 1'b1;
    clear_inputs();
    bus.funct = 4'd0; bus.in1 = 32'd0; bus.in2 = 32'd0; bus.mt_wdata = 32'd0;
    #1;
    chk("reset_hi", bus.hi, 0);
    chk("reset_lo", bus.lo, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_stall", bus.stall, 0);
    chk("reset_done", bus.done, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Non-muldiv funct must not start anything.
    bus.valid_in = 1'b1; bus.funct = 4'b0101;
    #1 chk("nonop_stall", bus.stall, 0);
    @(negedge clk);
    clear_inputs();
    chk("nonop_busy", bus.busy, 0);

    run_op(F_MULT,  32'hFFFFFFFE, 32'h00000003, 0, 0, 1'b0, 32'd0);
    run_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1'b0, 32'd0);
    run_op(F_DIV,   32'hFFFFFFF9, 32'd2,        0, 0, 1'b0, 32'd0);
    run_op(F_DIVU,  32'd100,      32'd0,        0, 0, 1'b0, 32'd0);
    run_op(F_DIV,   32'h80000000, 32'hFFFFFFFF, 0, 0, 1'b0, 32'd0);
    run_op(F_DIVU,  32'd100,      32'd7,        10, 0, 1'b0, 32'd0);
    run_op(F_MULTU, 32'd6,        32'd7,        0, 0, 1'b0, 32'd0);
    run_op(F_MULTU, 32'd6,        32'd7,        0, MULC, 1'b1, 32'h1234);
    run_op(F_DIV,   32'd7,        32'hFFFFFFFE, 0, 33, 1'b0, 32'hCAFE0001);
    mt_write(1'b0, 32'hDEADBEEF);
    mt_write(1'b1, 32'h0BADF00D);

    for (int i = 0; i < 40; i++) begin
      f = ops[$urandom_range(0, 3)];
      a = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      run_op(f, a, b, 0, 0, 1'b0, 32'd0);
    end

    // Asynchronous reset in the middle of a divide.
    bus.valid_in = 1'b1; bus.funct = F_DIV; bus.in1 = 32'h12345678; bus.in2 = 32'd3;
    @(negedge clk);
    clear_inputs();
    repeat (9) @(negedge clk);
    chk("pre_reset_busy", bus.busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_busy", bus.busy, 0);
    chk("async_stall", bus.stall, 0);
    chk("async_hi", bus.hi, 0);
    chk("async_lo", bus.lo, 0);
    @(negedge clk);
    reset = 1'b0;
    model_hi = 32'd0;
    model_lo = 32'd0;
    @(negedge clk);
    run_op(F_MULT, 32'h7FFFFFFF, 32'h80000000, 0, 0, 1'b0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Multi-cycle HI/LO unit for the execute stage. It replaces the single-cycle combinational multiply/divide path.
- It accepts MULT/MULTU/DIV/DIVU from execute and sequences a counted multiply or a 32-step restoring divide.
- It stalls the pipeline while busy and owns the architectural HI/LO registers, including MTHI/MTLO writes.

Parameters:
- MUL_CYCLES, 4, cycles spent in MUL state, legal range 1..16.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- valid_in  in  1  execute stage holds a valid instruction
- funct  in  4  op code: 4'b1011 MULT, 4'b1100 MULTU, 4'b1101 DIV, 4'b1110 DIVU; any other value is not a muldiv op
- in1  in  32  rs operand (dividend / multiplicand)
- in2  in  32  rt operand (divisor / multiplier)
- flush  in  1  cancel the in-flight op
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- mt_wdata  in  32  MTHI/MTLO data
- stall  out  1  freeze the execute stage and earlier stages
- busy  out  1  state is not IDLE
- done  out  1  one-cycle completion pulse
- hi  out  32  architectural HI
- lo  out  32  architectural LO

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous, active-high. On reset: state=IDLE, hi=0, lo=0, done=0, busy=0, stall=0, counter=0.
- start = valid_in & (funct is one of the 4 codes) & state==IDLE & ~flush.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - On start, latch funct, in1 and in2. For DIV, also latch |in1|, |in2|, sign_q=in1[31]^in2[31] and sign_r=in1[31]. Clear the counter.
  - Next state is MUL for MULT/MULTU.
  - Next state is DIV when the divisor is nonzero; DONE directly when in2==0 (HI/LO unchanged).
- MUL:
  - Counter increments each cycle; after MUL_CYCLES cycles in MUL, go to DONE.
  - On the MUL→DONE edge write the 64-bit product: {hi,lo}. MULT = sign-extended(in1) * sign-extended(in2). MULTU = zero-extended operands.
- DIV:
  - Restoring divide of magnitudes, 32 iterations, one quotient bit per cycle, MSB first. 33-bit partial remainder.
  - After iteration 32, go to FIX.
- FIX:
  - Write lo=quotient and hi=remainder. DIVU takes them unsigned. DIV negates the quotient when sign_q=1 and the remainder when sign_r=1.
  - Next state is DONE.
- DONE: done=1 for this single cycle, stall=0, next state IDLE. valid_in seen in DONE is the op just completed and is ignored.
- stall = start | (state in {MUL, DIV, FIX}). Stall is low in IDLE without start and low in DONE.
- Latency (start accepted in cycle T):
  - MULT/MULTU: done at T+1+MUL_CYCLES.
  - DIV/DIVU: done at T+34.
  - Divide by zero: done at T+1.
  - HI/LO hold the new result in the DONE cycle.
- Flush:
  - Any state goes to IDLE on the next edge.
  - No HI/LO result write and no done pulse.
  - The counter is cleared.
  - Flush outranks start and completion.
- MTHI/MTLO:
  - hi_we/lo_we write mt_wdata on the edge in any state.
  - If one coincides with a result write (MUL→DONE or FIX→DONE edge), the MT write wins for that register; the other register still takes the result.
- Overflow corner: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. No exception.
- Back-to-back ops: a new op can start at the earliest in the IDLE cycle after DONE (one bubble minimum).

Test Plan:
- MULT in1=0xFFFFFFFE (-2), in2=0x00000003 -> stall high for MUL_CYCLES+1 cycles, done at T+5, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU in1=0xFFFFFFFF, in2=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV in1=0xFFFFFFF9 (-7), in2=2 -> done at T+34, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU in1=100, in2=0 -> done at T+1, HI/LO unchanged.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 100/7 with flush asserted at T+10 -> IDLE at T+11, no done, HI/LO unchanged. A following MULTU 6*7 starts the next cycle and gives lo=42, hi=0.
- mtlo_we with mt_wdata=0x1234 on the same edge as MULTU 6*7 completion -> lo=0x1234, hi=0.
- Async reset mid-DIV -> state IDLE, hi=lo=0, stall=0 immediately, without waiting for a clock edge.
